// File: rtl/fft_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_streamer
// Purpose  : Buffers strobed real samples and streams them as zero-imaginary
//            complex AXI4-Stream words with framing, flush padding, overflow.
// Revision : 1.0
// ============================================================================
module fft_frame_streamer #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 2048,
    parameter int MIN_LOG2 = 3,
    parameter int MAX_LOG2 = 11
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic [DATA_W-1:0]          sample_in,
    input  logic                       sample_valid,
    input  logic [3:0]                 frameSize,
    input  logic                       flush,
    output logic [2*DATA_W-1:0]        tData,
    output logic                       tValid,
    output logic                       tLast,
    input  logic                       tReady,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic [15:0]                frames_done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int CW = MAX_LOG2;

    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [3:0]    MIN_EXP    = 4'(MIN_LOG2);
    localparam logic [3:0]    MAX_EXP    = 4'(MAX_LOG2);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_PAD    = 2'd2;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;

    logic [1:0]        state;
    logic [1:0]        next_state;
    logic [CW-1:0]     count;
    logic [CW-1:0]     last_idx;
    logic [CW-1:0]     last_idx_new;
    logic [CW-1:0]     cur_last_idx;
    logic [3:0]        exp_clamped;
    logic              pad_req;

    logic              out_free;
    logic              load;
    logic              load_zero;
    logic              load_last;

    assign fifo_empty = (fifo_level == '0);
    assign fifo_full  = (fifo_level == FULL_LEVEL);
    assign out_free   = !tValid || tReady;
    // A full FIFO still accepts a sample when a word leaves on the same edge.
    assign push       = sample_valid && (!fifo_full || pop);

    always_comb begin
        exp_clamped = frameSize;
        if (frameSize < MIN_EXP) begin
            exp_clamped = MIN_EXP;
        end else if (frameSize > MAX_EXP) begin
            exp_clamped = MAX_EXP;
        end
    end

    assign last_idx_new = CW'((32'd1 << exp_clamped) - 32'd1);

    // ------------------------------------------------------------------
    // Sample FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Framing FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_IDLE;
            count    <= '0;
            last_idx <= '0;
            pad_req  <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && next_state == S_STREAM) begin
                last_idx <= last_idx_new;
            end
            if (load_last) begin
                count <= '0;
            end else if (load) begin
                count <= count + 1'b1;
            end
            // A flush coinciding with the frame's final word is dropped.
            if (load_last) begin
                pad_req <= 1'b0;
            end else if (state == S_STREAM && flush) begin
                pad_req <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Framing FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    next_state = S_STREAM;
                end
            end
            S_STREAM: begin
                if (load_last) begin
                    next_state = S_IDLE;
                end else if (pad_req && fifo_empty && out_free) begin
                    next_state = S_PAD;
                end
            end
            S_PAD: begin
                if (load_last) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Framing FSM: output logic
    // ------------------------------------------------------------------
    // IDLE loads the first word in the cycle it leaves, keeping one-cycle
    // latency and full throughput across frame boundaries.
    always_comb begin
        load         = 1'b0;
        pop          = 1'b0;
        load_zero    = 1'b0;
        cur_last_idx = (state == S_IDLE) ? last_idx_new : last_idx;
        case (state)
            S_IDLE, S_STREAM: begin
                if (out_free && !fifo_empty) begin
                    load = 1'b1;
                    pop  = 1'b1;
                end
            end
            S_PAD: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_zero = 1'b1;
                end
            end
            default: begin
                load = 1'b0;
            end
        endcase
        load_last = load && (count == cur_last_idx);
    end

    // ------------------------------------------------------------------
    // Output register and status
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tData       <= '0;
            tValid      <= 1'b0;
            tLast       <= 1'b0;
            overflow    <= 1'b0;
            frames_done <= '0;
        end else begin
            if (load) begin
                tValid <= 1'b1;
                tLast  <= load_last;
                tData  <= load_zero ? '0 : {{DATA_W{1'b0}}, mem[rd_ptr]};
            end else if (tReady) begin
                tValid <= 1'b0;
                tLast  <= 1'b0;
            end
            if (tValid && tReady && tLast) begin
                frames_done <= frames_done + 16'd1;
            end
            if (sample_valid && !push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_frame_streamer
// Purpose  : Scoreboard bench for fft_frame_streamer with directed vectors.
// Revision : 1.0
// ============================================================================
module tb_fft_frame_streamer;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int LW     = $clog2(DEPTH + 1);

    logic                CLK = 1'b0;
    logic                RST_N;
    logic [DATA_W-1:0]   sample_in;
    logic                sample_valid;
    logic [3:0]          frameSize;
    logic                flush;
    logic [2*DATA_W-1:0] tData;
    logic                tValid;
    logic                tLast;
    logic                tReady;
    logic                overflow;
    logic [LW-1:0]       fifo_level;
    logic [15:0]         frames_done;

    always #5 CLK = ~CLK;

    fft_frame_streamer #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .MIN_LOG2 (3),
        .MAX_LOG2 (11)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .frameSize    (frameSize),
        .flush        (flush),
        .tData        (tData),
        .tValid       (tValid),
        .tLast        (tLast),
        .tReady       (tReady),
        .overflow     (overflow),
        .fifo_level   (fifo_level),
        .frames_done  (frames_done)
    );

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   xfers    = 0;
    logic prev_stall = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Monitor: transfers are judged at the negedge preceding the edge that completes them.
    always @(negedge CLK) begin
        exp_t e;
        if (prev_stall) begin
            check("hold_valid", 32'(tValid), 32'd1);
        end
        if (tValid && tReady) begin
            xfers++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got 0x%08h last=%0b, required no transfer", tData, tLast);
            end else begin
                e = exp_q.pop_front();
                check("xfer_data", tData, e.data);
                check("xfer_last", 32'(tLast), 32'(e.last));
            end
        end
        prev_stall = tValid && !tReady;
    end

    task automatic push_exp(input logic [31:0] d, input logic l);
        exp_t e;
        e.last = l;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic write_one(input logic [15:0] d, input logic l, input bit accepted);
        @(posedge CLK);
        #1;
        sample_valid = 1'b1;
        sample_in    = d;
        if (accepted) begin
            push_exp({16'h0000, d}, l);
        end
    endtask

    task automatic idle_in();
        @(posedge CLK);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic pulse_flush(input int nzero);
        @(posedge CLK);
        #1;
        sample_valid = 1'b0;
        flush        = 1'b1;
        for (int i = 0; i < nzero; i++) begin
            push_exp(32'h0, (i == nzero - 1));
        end
        @(posedge CLK);
        #1;
        flush = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && !tValid) break;
        end
        n_checks++;
        if (i == budget) begin
            n_fail++;
            $display("FAIL %s: drain timeout, %0d words outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic write_frame(input logic [15:0] base, input int n, input int len);
        for (int i = 0; i < n; i++) begin
            write_one(base + 16'(i), ((i % len) == len - 1), 1'b1);
        end
        idle_in();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int k;
        RST_N        = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        frameSize    = 4'd3;
        flush        = 1'b0;
        tReady       = 1'b1;

        #2;
        check("rst_valid", 32'(tValid), 32'd0);
        check("rst_last", 32'(tLast), 32'd0);
        check("rst_data", tData, 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_frames", 32'(frames_done), 32'd0);
        #20;
        RST_N = 1'b1;

        // Test 1: basic frame of 8 with latency check
        @(posedge CLK);
        #1;
        sample_valid = 1'b1;
        sample_in    = 16'd1;
        push_exp(32'd1, 1'b0);
        @(posedge CLK);
        #1;
        check("lat_after_write_edge", 32'(tValid), 32'd0);
        sample_in = 16'd2;
        push_exp(32'd2, 1'b0);
        @(posedge CLK);
        #1;
        check("lat_after_next_edge", 32'(tValid), 32'd1);
        check("lat_first_data", tData, 32'd1);
        sample_in = 16'd3;
        push_exp(32'd3, 1'b0);
        for (int i = 4; i <= 8; i++) begin
            write_one(16'(i), (i == 8), 1'b1);
        end
        idle_in();
        wait_drain("t1_drain", 50);
        check("t1_frames", 32'(frames_done), 32'd1);

        // Test 2: backpressure 1,0,0,1
        fork
            write_frame(16'd1, 8, 8);
            begin
                for (int i = 0; i < 40; i++) begin
                    @(posedge CLK);
                    #1;
                    tReady = ((i % 4) == 0) || ((i % 4) == 3);
                end
            end
        join
        tReady = 1'b1;
        wait_drain("t2_drain", 50);
        check("t2_frames", 32'(frames_done), 32'd2);

        // Test 3a: frameSize 0 clamps to 8
        frameSize = 4'd0;
        write_frame(16'h0030, 8, 8);
        wait_drain("t3a_drain", 50);
        check("t3a_frames", 32'(frames_done), 32'd3);

        // Test 3b: change 3 -> 4 mid-frame
        frameSize = 4'd3;
        for (int i = 0; i < 24; i++) begin
            write_one(16'h0040 + 16'(i), (i == 7) || (i == 23), 1'b1);
            if (i == 3) frameSize = 4'd4;
        end
        idle_in();
        wait_drain("t3b_drain", 80);
        check("t3b_frames", 32'(frames_done), 32'd5);

        // Test 3c: frameSize 15 clamps to 2048
        frameSize = 4'd15;
        for (int i = 0; i < 2048; i++) begin
            write_one(i[15:0], (i == 2047), 1'b1);
        end
        idle_in();
        wait_drain("t3c_drain", 200);
        check("t3c_frames", 32'(frames_done), 32'd6);

        // Test 4: flush after 5 samples of a 16-point frame
        frameSize = 4'd4;
        write_frame(16'h0050, 5, 16);
        pulse_flush(11);
        wait_drain("t4_drain", 80);
        check("t4_frames", 32'(frames_done), 32'd7);
        check("t4_level", 32'(fifo_level), 32'd0);

        // Test 5: overflow with tReady low
        check("t5_no_overflow_yet", 32'(overflow), 32'd0);
        frameSize = 4'd4;
        tReady    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            write_one(16'h0060 + 16'(i), (i == 15), (i < 17));
        end
        idle_in();
        check("t5_level_full", 32'(fifo_level), 32'd16);
        check("t5_overflow", 32'(overflow), 32'd1);
        @(posedge CLK);
        #1;
        tReady = 1'b1;
        repeat (24) @(posedge CLK);
        #1;
        check("t5_overflow_sticky", 32'(overflow), 32'd1);
        check("t5_level_empty", 32'(fifo_level), 32'd0);
        pulse_flush(15);
        wait_drain("t5_drain", 80);
        check("t5_frames", 32'(frames_done), 32'd9);

        // Test 6: asynchronous reset after 3 of 8 transfers
        frameSize = 4'd3;
        tReady    = 1'b0;
        write_frame(16'h0070, 8, 8);
        base = xfers;
        @(posedge CLK);
        #1;
        tReady = 1'b1;
        for (k = 0; k < 20; k++) begin
            @(posedge CLK);
            if (xfers >= base + 3) break;
        end
        n_checks++;
        if (k == 20) begin
            n_fail++;
            $display("FAIL t6_wait_xfers: got %0d transfers, required 3", xfers - base);
        end
        #1;
        tReady = 1'b0;
        #2;
        RST_N = 1'b0;
        exp_q.delete();
        #1;
        check("t6_rst_valid", 32'(tValid), 32'd0);
        check("t6_rst_last", 32'(tLast), 32'd0);
        check("t6_rst_data", tData, 32'd0);
        check("t6_rst_level", 32'(fifo_level), 32'd0);
        check("t6_rst_frames", 32'(frames_done), 32'd0);
        check("t6_rst_overflow", 32'(overflow), 32'd0);
        #4;
        RST_N  = 1'b1;
        tReady = 1'b1;
        write_frame(16'h0080, 8, 8);
        wait_drain("t6_drain", 50);
        check("t6_frames", 32'(frames_done), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
